// File: rtl/host_mem_responder_if.sv
// Line-request bus between a host-memory requester and its responder.
// The requester holds a valid until the matching completion pulse.
interface host_mem_responder_if;
  logic         read_request_valid;
  logic         write_request_valid;
  logic [31:0]  address;
  logic [511:0] data_d;
  logic         buffer_addr_valid;
  logic         data_valid;
  logic         write_done;
  logic [511:0] data_q;
  logic         addr_err;

  modport master (
    output read_request_valid, write_request_valid, address, data_d,
    input  buffer_addr_valid, data_valid, write_done, data_q, addr_err
  );

  modport slave (
    input  read_request_valid, write_request_valid, address, data_d,
    output buffer_addr_valid, data_valid, write_done, data_q, addr_err
  );
endinterface

// File: rtl/host_mem_responder.sv
// On-chip host-memory stand-in: a DEPTH x 512-bit line store answering one
// read or write at a time with fixed, programmable latencies.
module host_mem_responder #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  host_mem_responder_if.slave  bus
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   clear_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [IDX_W-1:0]   idx_q;
  logic               in_range_q;
  logic [511:0]       wdata_q;

  logic [511:0]       store [DEPTH];
  logic               store_we;
  logic [IDX_W-1:0]   store_waddr;
  logic [511:0]       store_wdata;

  logic               in_range;
  logic               lat_zero;

  // Full 32-bit compare: upper address bits must never alias into the store.
  assign in_range = bus.address < 32'(DEPTH);
  assign lat_zero = (lat_cnt == '0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the ifs can leave it unassigned and infer a latch.
  always_comb begin
    store_we    = 1'b0;
    store_waddr = clear_cnt;
    store_wdata = '0;
    if (state == INIT) begin
      store_we = 1'b1;
    end else if (state == WR_WAIT && lat_zero && in_range_q) begin
      store_we    = 1'b1;
      store_waddr = idx_q;
      store_wdata = wdata_q;
    end
  end

  // NOTE: the line store has no reset term so it maps onto block RAM; the
  // INIT sweep is what zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store[store_waddr] <= store_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= INIT;
      clear_cnt             <= '0;
      lat_cnt               <= '0;
      idx_q                 <= '0;
      in_range_q            <= 1'b0;
      wdata_q               <= '0;
      bus.buffer_addr_valid <= 1'b0;
      bus.data_valid        <= 1'b0;
      bus.write_done        <= 1'b0;
      bus.data_q            <= '0;
      bus.addr_err          <= 1'b0;
    end else begin
      // Completion pulses default low so each lasts exactly one cycle.
      bus.data_valid <= 1'b0;
      bus.write_done <= 1'b0;

      case (state)
        INIT: begin
          clear_cnt <= clear_cnt + IDX_W'(1);
          if (clear_cnt == IDX_W'(DEPTH - 1)) begin
            bus.buffer_addr_valid <= 1'b1;
            state                 <= IDLE;
          end
        end

        IDLE: begin
          if (bus.read_request_valid) begin
            idx_q      <= bus.address[IDX_W-1:0];
            in_range_q <= in_range;
            lat_cnt    <= LAT_W'(RD_LAT - 1);
            if (!in_range) bus.addr_err <= 1'b1;
            state      <= RD_WAIT;
          end else if (bus.write_request_valid) begin
            idx_q      <= bus.address[IDX_W-1:0];
            in_range_q <= in_range;
            wdata_q    <= bus.data_d;
            lat_cnt    <= LAT_W'(WR_LAT - 1);
            if (!in_range) bus.addr_err <= 1'b1;
            state      <= WR_WAIT;
          end
        end

        RD_WAIT: begin
          if (lat_zero) begin
            bus.data_q     <= in_range_q ? store[idx_q] : '0;
            bus.data_valid <= 1'b1;
            state          <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        WR_WAIT: begin
          if (lat_zero) begin
            bus.write_done <= 1'b1;
            state          <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        // One dead cycle lets the requester drop its valid before IDLE looks again.
        DONE: state <= IDLE;

        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_host_mem_responder.sv
// Self-checking bench for host_mem_responder: table vectors, directed corner
// sequences and randomized traffic against a line-array reference model.
module tb_host_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  host_mem_responder_if bus ();

  host_mem_responder #(
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the store as a plain array plus the sticky error flag.
  logic [511:0] model_mem [DEPTH];
  bit           model_err;

  typedef struct {
    bit           rd;
    logic [31:0]  addr;
    logic [511:0] data;
    logic [511:0] exp_q;
    bit           exp_err;
  } vec_t;

  vec_t vec [13];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return a < 32'(DEPTH);
  endfunction

  function automatic logic [511:0] model_read(input logic [31:0] a);
    return model_in_range(a) ? model_mem[a[$clog2(DEPTH)-1:0]] : '0;
  endfunction

  function automatic void model_access(input bit rd, input logic [31:0] a, input logic [511:0] d);
    if (!model_in_range(a)) model_err = 1'b1;
    else if (!rd) model_mem[a[$clog2(DEPTH)-1:0]] = d;
  endfunction

  function automatic void model_clear();
    foreach (model_mem[i]) model_mem[i] = '0;
    model_err = 1'b0;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Counts edges until a completion pulse; checks the latency and pulse kind.
  // With scramble set, address/data_d are trashed right after acceptance.
  task automatic wait_pulse(input bit want_rd, input int exp_n, input string name, input bit scramble);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 1) begin
        bus.address = $urandom;
        bus.data_d  = rand_line();
      end
      if (bus.data_valid || bus.write_done) seen = 1'b1;
    end
    check({name, "_latency"}, n, exp_n);
    check({name, "_kind"}, {bus.data_valid, bus.write_done}, want_rd ? 2'b10 : 2'b01);
  endtask

  // One transaction issued from IDLE; leaves the DUT back in IDLE.
  task automatic txn(input bit rd, input logic [31:0] a, input logic [511:0] d, input string name);
    bus.read_request_valid  = rd;
    bus.write_request_valid = !rd;
    bus.address             = a;
    bus.data_d              = d;
    wait_pulse(rd, (rd ? RD_LAT : WR_LAT) + 1, name, 1'b1);
    model_access(rd, a, d);
    if (rd) check({name, "_data"}, bus.data_q, model_read(a));
    check({name, "_err"}, bus.addr_err, model_err);
    bus.read_request_valid  = 1'b0;
    bus.write_request_valid = 1'b0;
    @(posedge clk); #1;
    check({name, "_width"}, {bus.data_valid, bus.write_done}, 2'b00);
  endtask

  // Counts edges from reset release until buffer_addr_valid rises.
  task automatic wait_ready(input string name);
    int n;
    bit pulse_seen;
    n = 0;
    pulse_seen = 1'b0;
    while (!bus.buffer_addr_valid && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (bus.data_valid || bus.write_done) pulse_seen = 1'b1;
    end
    check({name, "_init_cycles"}, n, DEPTH);
    check({name, "_init_quiet"}, pulse_seen, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec = '{
      '{1'b0, 32'd7,          {64{8'hA5}},        '0,                 1'b0},
      '{1'b1, 32'd7,          '0,                 {64{8'hA5}},        1'b0},
      '{1'b0, 32'd1023,       {16{32'hDEADBEEF}}, '0,                 1'b0},
      '{1'b1, 32'd1023,       '0,                 {16{32'hDEADBEEF}}, 1'b0},
      '{1'b0, 32'd0,          {512{1'b1}},        '0,                 1'b0},
      '{1'b1, 32'd0,          '0,                 {512{1'b1}},        1'b0},
      '{1'b1, 32'd1,          '0,                 '0,                 1'b0},
      '{1'b0, 32'd7,          512'h1234,          '0,                 1'b0},
      '{1'b1, 32'd7,          '0,                 512'h1234,          1'b0},
      '{1'b1, 32'h0000_0400,  '0,                 '0,                 1'b1},
      '{1'b0, 32'h8000_0000,  {16{32'h5555AAAA}}, '0,                 1'b1},
      '{1'b1, 32'd0,          '0,                 {512{1'b1}},        1'b1},
      '{1'b1, 32'd7,          '0,                 512'h1234,          1'b1}
    };

    bus.read_request_valid  = 1'b0;
    bus.write_request_valid = 1'b0;
    bus.address             = '0;
    bus.data_d              = '0;
    model_clear();

    // Reset values, then INIT length with a read already waiting.
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {bus.buffer_addr_valid, bus.data_valid, bus.write_done, bus.addr_err}, 4'b0000);
    check("reset_data_q", bus.data_q, '0);
    bus.read_request_valid = 1'b1;
    bus.address            = 32'd5;
    rst = 1'b0;
    wait_ready("init1");
    wait_pulse(1'b1, RD_LAT + 1, "rd5", 1'b0);
    check("rd5_data", bus.data_q, 512'h0);
    bus.read_request_valid = 1'b0;
    @(posedge clk); #1;
    check("rd5_width", bus.data_valid, 1'b0);

    // Read and write together: read first, write accepted after DONE+IDLE.
    bus.read_request_valid  = 1'b1;
    bus.write_request_valid = 1'b1;
    bus.address             = 32'd3;
    bus.data_d              = 512'h1;
    wait_pulse(1'b1, RD_LAT + 1, "both_rd", 1'b0);
    check("both_rd_data", bus.data_q, model_read(32'd3));
    bus.read_request_valid = 1'b0;
    wait_pulse(1'b0, WR_LAT + 2, "both_wr", 1'b0);
    model_access(1'b0, 32'd3, 512'h1);
    bus.write_request_valid = 1'b0;
    @(posedge clk); #1;
    check("both_wr_width", bus.write_done, 1'b0);
    txn(1'b1, 32'd3, '0, "both_rb");
    check("both_rb_value", bus.data_q, 512'h1);

    // Table vectors, including out-of-range read and write.
    for (int i = 0; i < 13; i++) begin
      txn(vec[i].rd, vec[i].addr, vec[i].data, $sformatf("vec%0d", i));
      if (vec[i].rd) check($sformatf("vec%0d_table_q", i), bus.data_q, vec[i].exp_q);
      check($sformatf("vec%0d_table_err", i), bus.addr_err, vec[i].exp_err);
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      bit          rd;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0400;
      else a = 32'($urandom_range(0, 15));
      txn(rd, a, rand_line(), $sformatf("rand%0d", t));
    end

    // Read held high through completions: re-accepted every RD_LAT+2 cycles.
    bus.read_request_valid = 1'b1;
    bus.address            = 32'd7;
    wait_pulse(1'b1, RD_LAT + 1, "hold0", 1'b0);
    check("hold0_data", bus.data_q, model_read(32'd7));
    for (int p = 1; p <= 3; p++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_gap", p), bus.data_valid, 1'b0);
      wait_pulse(1'b1, RD_LAT + 1, $sformatf("hold%0d", p), 1'b0);
    end
    bus.read_request_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_end_width", bus.data_valid, 1'b0);

    // Asynchronous reset in the middle of RD_WAIT.
    bus.read_request_valid = 1'b1;
    bus.address            = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_flags", {bus.buffer_addr_valid, bus.data_valid, bus.write_done, bus.addr_err}, 4'b0000);
    check("midrst_data_q", bus.data_q, '0);
    bus.read_request_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_quiet%0d", k), bus.data_valid, 1'b0);
    end
    rst = 1'b0;
    model_clear();
    wait_ready("init2");
    txn(1'b1, 32'd7, '0, "postrst_rd7");
    txn(1'b1, 32'd0, '0, "postrst_rd0");
    txn(1'b1, 32'd3, '0, "postrst_rd3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/host_mem_responder.md
Name: host_mem_responder

Overview:
- Responder end of the simple line-request interface that the CCI-P memory requester drives: read_request_valid / write_request_valid / address / data_d in, data_valid / write_done / data_q / buffer_addr_valid out.
- Services requests from an on-chip line store of DEPTH 512-bit lines, with programmable fixed latencies.
- Used as the host-memory stand-in for the control and pipeline path: on-FPGA bring-up, and unit benches of the controller without a CCI-P shell.

Parameters:
- DEPTH, 1024, number of 512-bit lines in the store (power of two, >= 2).
- RD_LAT, 4, cycles from read acceptance to data_valid (>= 1).
- WR_LAT, 2, cycles from write acceptance to write_done (>= 1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- read_request_valid  input  1  level; read request; held by the requester until data_valid.
- write_request_valid  input  1  level; write request; held by the requester until write_done.
- address  input  32  line index (64-byte units); sampled at acceptance.
- data_d  input  512  write data; sampled at acceptance.
- buffer_addr_valid  output  1  store initialised and ready; high from end of INIT until next reset.
- data_valid  output  1  one-cycle pulse; data_q valid.
- write_done  output  1  one-cycle pulse; write committed.
- data_q  output  512  read data; held until next read completion.
- addr_err  output  1  sticky; set by any access with address >= DEPTH.

Behaviour:
- Reset (async, any state, including mid-transaction):
  - buffer_addr_valid, data_valid, write_done and addr_err = 0; data_q = 0.
  - State = INIT, clear counter = 0, latency counter = 0.
  - In-flight transaction is discarded; no completion pulse.
- States: INIT, IDLE, RD_WAIT, WR_WAIT, DONE.
- INIT:
  - Zero one line per cycle, index 0..DEPTH-1, taking exactly DEPTH cycles.
  - Requests are ignored in INIT.
  - On the edge that clears line DEPTH-1: buffer_addr_valid <= 1, go to IDLE.
- IDLE (acceptance is the edge at which a valid is sampled high here):
  - read_request_valid = 1: capture address, latency counter <= RD_LAT-1, go to RD_WAIT.
  - Else if write_request_valid = 1: capture address and data_d, counter <= WR_LAT-1, go to WR_WAIT.
  - Both high in the same cycle: read wins; the write stays pending and is accepted from IDLE after the read completes.
- RD_WAIT:
  - Counter decrements once per cycle; at 0, on the next edge:
    - data_q <= store[addr], or all zeros if addr >= DEPTH.
    - data_valid <= 1 for one cycle; go to DONE.
  - Net latency: acceptance at edge k gives data_valid high in the cycle after edge k+RD_LAT.
- WR_WAIT:
  - Same counting; at 0, on the next edge:
    - store[addr] <= captured data if addr < DEPTH; otherwise the write is dropped.
    - write_done <= 1 for one cycle; go to DONE.
  - A read accepted after write_done returns the new data.
- DONE:
  - Lasts one cycle; pulses return to 0; requests are ignored; then go to IDLE.
  - This gives the requester one registered cycle to drop its valid.
  - A valid still high on return to IDLE is treated as a new request.
- Out-of-range access (address >= DEPTH):
  - addr_err <= 1 at acceptance and stays set until reset.
  - The transaction still completes with normal timing.
  - Address upper bits are never truncated or wrapped.
- One outstanding transaction only. address and data_d changes after acceptance have no effect.
- Store indexing uses address[$clog2(DEPTH)-1:0] only after the range check passes.

Test Plan:
- Reset, then wait: buffer_addr_valid = 0 for exactly 1024 cycles, then 1. A read of line 5 returns 512'h0 with data_valid 5 cycles after the acceptance edge (RD_LAT=4).
- Write 512'hA5A5…A5 to line 7 → write_done pulses exactly once, 3 cycles after acceptance. A subsequent read of line 7 → data_q = A5…A5, data_valid a single cycle wide.
- Both valids high with address 3 and data_d = 512'h1 → read completes first with data 0. The write is then accepted after DONE+IDLE. A following read of line 3 returns 512'h1.
- Read of address 32'h0000_0400 (=DEPTH) → data_q = 0, data_valid pulses, addr_err = 1. Write to 32'h8000_0000 → write_done pulses, store unchanged, addr_err stays 1.
- Assert rst during RD_WAIT → all outputs 0 asynchronously, no data_valid pulse. INIT reruns for 1024 cycles; previously written lines read back 0.
- Hold read_request_valid high through completion → a second read is accepted in the IDLE cycle after DONE. data_valid pulses recur every RD_LAT+2 cycles, never back-to-back.
